// File: rtl/security_pkg.sv
// Shared encodings and widths for the lock's anti-tamper logic.
package security_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_ALARM  = 2'd2;

    localparam int unsigned FAIL_W = 3;
    localparam int unsigned SECS_W = 8;
    localparam int unsigned LOCK_W = 3;

endpackage

// File: rtl/thief_lockout_ctrl_if.sv
// Password-event inputs and status outputs of the lockout controller.
interface thief_lockout_ctrl_if;
    import security_pkg::*;

    logic              pass_ok;
    logic              pass_fail;
    logic              admin_clear;
    logic              locked;
    logic              alarm;
    logic [FAIL_W-1:0] fail_cnt;
    logic [SECS_W-1:0] secs_left;
    logic              tick_out;

    modport master (
        output pass_ok, pass_fail, admin_clear,
        input  locked, alarm, fail_cnt, secs_left, tick_out
    );

    modport slave (
        input  pass_ok, pass_fail, admin_clear,
        output locked, alarm, fail_cnt, secs_left, tick_out
    );

endinterface

// File: rtl/tick_prescaler.sv
// Synchronous restartable divider: one registered tick every TICK_DIV cycles.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned     CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_tick;

    always_comb begin
        if (restart || (r_cnt >= LAST)) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // Tick is registered alongside the count so it is high exactly while r_cnt == LAST.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tick <= (w_cnt_nxt == LAST);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/thief_lockout_ctrl.sv
// Anti-tamper sequencer: counts wrong passwords, times keypad lockouts, latches a sticky alarm.
module thief_lockout_ctrl
    import security_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned MAX_FAIL  = 3,
    parameter int unsigned LOCK_SECS = 30,
    parameter int unsigned MAX_LOCKS = 3
) (
    input logic                 clk_in,
    input logic                 rst_n,
    thief_lockout_ctrl_if.slave bus
);

    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(MAX_LOCKS - 1);
    localparam logic [SECS_W-1:0] SECS_INIT = SECS_W'(LOCK_SECS);
    localparam logic [SECS_W-1:0] SECS_ONE  = SECS_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [FAIL_W-1:0] r_fail;
    logic [FAIL_W-1:0] w_fail_nxt;
    logic [LOCK_W-1:0] r_locks;
    logic [LOCK_W-1:0] w_locks_nxt;
    logic [SECS_W-1:0] r_secs;
    logic [SECS_W-1:0] w_secs_nxt;
    logic              r_locked;
    logic              r_alarm;
    logic              w_restart;
    logic              w_tick;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .restart (w_restart),
        .tick    (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_fail_nxt  = r_fail;
        w_locks_nxt = r_locks;
        w_secs_nxt  = r_secs;
        w_restart   = 1'b0;

        if (bus.admin_clear) begin
            w_state_nxt = ST_IDLE;
            w_fail_nxt  = '0;
            w_locks_nxt = '0;
            w_secs_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // pass_fail outranks pass_ok, so a simultaneous pair counts as a failure.
                    if (bus.pass_fail) begin
                        if (r_fail >= FAIL_LAST) begin
                            w_fail_nxt = '0;
                            if (r_locks != '1) begin
                                w_locks_nxt = r_locks + 1'b1;
                            end
                            if (r_locks >= LOCK_LAST) begin
                                w_state_nxt = ST_ALARM;
                                w_secs_nxt  = '0;
                            end else begin
                                w_state_nxt = ST_LOCKED;
                                w_secs_nxt  = SECS_INIT;
                                w_restart   = 1'b1;
                            end
                        end else begin
                            w_fail_nxt = r_fail + 1'b1;
                        end
                    end else if (bus.pass_ok) begin
                        w_fail_nxt  = '0;
                        w_locks_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_tick) begin
                        if (r_secs <= SECS_ONE) begin
                            w_state_nxt = ST_IDLE;
                            w_secs_nxt  = '0;
                        end else begin
                            w_secs_nxt = r_secs - 1'b1;
                        end
                    end
                end
                ST_ALARM: begin
                    w_secs_nxt = '0;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_secs_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_fail   <= '0;
            r_locks  <= '0;
            r_secs   <= '0;
            r_locked <= 1'b0;
            r_alarm  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_fail   <= w_fail_nxt;
            r_locks  <= w_locks_nxt;
            r_secs   <= w_secs_nxt;
            r_locked <= (w_state_nxt == ST_LOCKED) || (w_state_nxt == ST_ALARM);
            r_alarm  <= (w_state_nxt == ST_ALARM);
        end
    end

    assign bus.locked    = r_locked;
    assign bus.alarm     = r_alarm;
    assign bus.fail_cnt  = r_fail;
    assign bus.secs_left = r_secs;
    assign bus.tick_out  = w_tick;

endmodule

// File: tb/tb_thief_lockout_ctrl.sv
// Bench for thief_lockout_ctrl: directed vector table, reset corner case, randomized model compare.
module tb_thief_lockout_ctrl;

    localparam int unsigned TD = 4;
    localparam int unsigned MF = 3;
    localparam int unsigned LS = 2;
    localparam int unsigned ML = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    thief_lockout_ctrl_if bus ();

    thief_lockout_ctrl #(
        .TICK_DIV  (TD),
        .MAX_FAIL  (MF),
        .LOCK_SECS (LS),
        .MAX_LOCKS (ML)
    ) dut (
        .clk_in (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: timed lockout flag, alarm flag, plain integer counters,
    // and the prescaler phase as the number of edges since reset/restart.
    bit m_lk;
    bit m_al;
    int m_fail;
    int m_locks;
    int m_secs;
    int m_age;

    function automatic void model_reset();
        m_lk = 0; m_al = 0; m_fail = 0; m_locks = 0; m_secs = 0; m_age = 0;
    endfunction

    function automatic void model_step(bit ok, bit fl, bit cl);
        bit tick_now;
        bit restart;
        tick_now = ((m_age % TD) == TD - 1);
        restart  = 0;
        if (cl) begin
            m_lk = 0; m_al = 0; m_fail = 0; m_locks = 0; m_secs = 0;
        end else if (m_al) begin
            m_secs = 0;
        end else if (m_lk) begin
            if (tick_now) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) m_lk = 0;
            end
        end else if (fl) begin
            if (m_fail + 1 < MF) begin
                m_fail = m_fail + 1;
            end else begin
                m_fail  = 0;
                m_locks = m_locks + 1;
                if (m_locks == ML) begin
                    m_al = 1;
                end else begin
                    m_lk    = 1;
                    m_secs  = LS;
                    restart = 1;
                end
            end
        end else if (ok) begin
            m_fail  = 0;
            m_locks = 0;
        end
        m_age = restart ? 0 : m_age + 1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " locked"},    int'(bus.locked),    int'(m_lk | m_al));
        check({tag, " alarm"},     int'(bus.alarm),     int'(m_al));
        check({tag, " fail_cnt"},  int'(bus.fail_cnt),  m_fail);
        check({tag, " secs_left"}, int'(bus.secs_left), m_secs);
        check({tag, " tick_out"},  int'(bus.tick_out),  int'((m_age % TD) == TD - 1));
    endtask

    task automatic apply(input bit ok, input bit fl, input bit cl);
        bus.pass_ok     = ok;
        bus.pass_fail   = fl;
        bus.admin_clear = cl;
        @(posedge clk);
        model_step(ok, fl, cl);
        #1;
        bus.pass_ok     = 1'b0;
        bus.pass_fail   = 1'b0;
        bus.admin_clear = 1'b0;
    endtask

    typedef struct {
        bit ok;
        bit fl;
        bit cl;
        bit e_lk;
        bit e_al;
        int e_fc;
        int e_sl;
    } vec_t;

    vec_t vt[$];

    function automatic void add(bit ok, bit fl, bit cl, bit lk, bit al, int fc, int sl);
        vec_t v;
        v.ok = ok; v.fl = fl; v.cl = cl;
        v.e_lk = lk; v.e_al = al; v.e_fc = fc; v.e_sl = sl;
        vt.push_back(v);
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.pass_ok     = 1'b0;
        bus.pass_fail   = 1'b0;
        bus.admin_clear = 1'b0;
        rst_n = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset locked",    int'(bus.locked),    0);
        check("reset alarm",     int'(bus.alarm),     0);
        check("reset fail_cnt",  int'(bus.fail_cnt),  0);
        check("reset secs_left", int'(bus.secs_left), 0);
        check("reset tick_out",  int'(bus.tick_out),  0);
        rst_n = 1'b1;

        //  ok fl cl  lk al fc sl
        add(0, 1, 0,  0, 0, 1, 0);  // fail, fail, ok, fail
        add(0, 1, 0,  0, 0, 2, 0);
        add(1, 0, 0,  0, 0, 0, 0);
        add(0, 1, 0,  0, 0, 1, 0);
        add(0, 1, 0,  0, 0, 2, 0);
        add(0, 1, 0,  1, 0, 0, 2);  // third fail: lockout
        add(0, 0, 0,  1, 0, 0, 2);
        add(0, 1, 0,  1, 0, 0, 2);  // ignored while locked
        add(0, 0, 0,  1, 0, 0, 2);
        add(0, 0, 0,  1, 0, 0, 1);  // 4 cycles after lock
        add(1, 1, 0,  1, 0, 0, 1);
        add(0, 0, 0,  1, 0, 0, 1);
        add(0, 0, 0,  1, 0, 0, 1);
        add(0, 0, 0,  0, 0, 0, 0);  // 8 cycles after lock
        add(1, 1, 0,  0, 0, 1, 0);  // ok+fail counts as fail
        add(0, 1, 0,  0, 0, 2, 0);
        add(0, 1, 0,  1, 1, 0, 0);  // second lockout -> alarm
        add(1, 0, 0,  1, 1, 0, 0);
        add(0, 1, 0,  1, 1, 0, 0);
        add(0, 0, 1,  0, 0, 0, 0);  // admin clear
        add(0, 1, 0,  0, 0, 1, 0);
        add(0, 1, 0,  0, 0, 2, 0);
        add(0, 1, 1,  0, 0, 0, 0);  // clear beats third fail
        add(0, 1, 0,  0, 0, 1, 0);

        for (int i = 0; i < vt.size(); i++) begin
            apply(vt[i].ok, vt[i].fl, vt[i].cl);
            check($sformatf("vec%0d locked", i),    int'(bus.locked),    int'(vt[i].e_lk));
            check($sformatf("vec%0d alarm", i),     int'(bus.alarm),     int'(vt[i].e_al));
            check($sformatf("vec%0d fail_cnt", i),  int'(bus.fail_cnt),  vt[i].e_fc);
            check($sformatf("vec%0d secs_left", i), int'(bus.secs_left), vt[i].e_sl);
            check($sformatf("vec%0d tick_out", i),  int'(bus.tick_out),
                  int'((m_age % TD) == TD - 1));
        end

        // Reset in the middle of a lockout must clear everything, including the lockout count.
        apply(0, 0, 1);
        repeat (3) apply(0, 1, 0);
        apply(0, 0, 0);
        check("pre-reset locked", int'(bus.locked), 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async locked",    int'(bus.locked),    0);
        check("async alarm",     int'(bus.alarm),     0);
        check("async fail_cnt",  int'(bus.fail_cnt),  0);
        check("async secs_left", int'(bus.secs_left), 0);
        check("async tick_out",  int'(bus.tick_out),  0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) apply(0, 1, 0);
        check("post-reset lock locked", int'(bus.locked),    1);
        check("post-reset lock alarm",  int'(bus.alarm),     0);
        check("post-reset lock secs",   int'(bus.secs_left), LS);
        check_model("post-reset");

        for (int c = 0; c < 600; c++) begin
            bit r_ok;
            bit r_fl;
            bit r_cl;
            r_ok = ($urandom_range(0, 99) < 20);
            r_fl = ($urandom_range(0, 99) < 35);
            r_cl = ($urandom_range(0, 99) < 3);
            apply(r_ok, r_fl, r_cl);
            check_model($sformatf("rand%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
